// File: rtl/proc_param_if.sv
// Core-side bundle: fetch/run control, internal bus visibility and the req/ack memory port.
// The core attaches through master; the system side (memory, sequencer) through slave.
interface proc_param_if #(
  parameter int DATA_W = 16
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic [DATA_W-1:0] ADDR;
  logic [DATA_W-1:0] DOUT;
  logic              W;
  logic              MemReq;
  logic              MemAck;

  modport master (
    input  Run, DIN, MemAck,
    output Done, BusWires, ADDR, DOUT, W, MemReq
  );

  modport slave (
    output Run, DIN, MemAck,
    input  Done, BusWires, ADDR, DOUT, W, MemReq
  );
endinterface

// File: rtl/proc_param.sv
// Parametrised multicycle processor: NREG x DATA_W register file, shared bus, full ALU
// and load/store over a registered req/ack memory port.
module proc_param #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  proc_param_if.master  bus
);
  localparam int RW   = $clog2(NREG);
  localparam int IR_W = 4 + 2 * RW;
  localparam int SHW  = $clog2(DATA_W);

  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_MVNZ = 4'd2;
  localparam logic [3:0] OP_MV   = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;

  typedef enum logic [2:0] {T0, T1, T2, T3, MW} state_t;
  typedef enum logic [2:0] {BUS_NONE, BUS_RX, BUS_RY, BUS_DIN, BUS_G} bus_sel_t;

  state_t            state;
  state_t            state_nxt;
  bus_sel_t          bus_sel;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              w;
  logic              mem_req;

  logic [3:0]        opc;
  logic [RW-1:0]     x_idx;
  logic [RW-1:0]     y_idx;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;
  logic [DATA_W-1:0] bus_val;
  logic              is_alu;
  logic              done;
  logic              rx_we;
  logic              a_we;
  logic              g_we;
  logic              mem_start;

  function automatic logic [DATA_W-1:0] alu(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] lhs,
    input logic [DATA_W-1:0] rhs
  );
    logic signed [DATA_W-1:0] s_lhs;
    logic signed [DATA_W-1:0] s_rhs;
    logic                     lt;
    s_lhs = lhs;
    s_rhs = rhs;
    lt    = (s_lhs < s_rhs);
    case (op)
      OP_ADD:  alu = lhs + rhs;
      OP_SUB:  alu = lhs - rhs;
      OP_OR:   alu = lhs | rhs;
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, lt};
      OP_SLL:  alu = lhs << rhs[SHW-1:0];
      OP_SRL:  alu = lhs >> rhs[SHW-1:0];
      default: alu = '0;
    endcase
  endfunction

  assign opc    = ir[IR_W-1 -: 4];
  assign x_idx  = ir[2*RW-1 -: RW];
  assign y_idx  = ir[RW-1:0];
  assign rx_val = regs[x_idx];
  assign ry_val = regs[y_idx];
  assign is_alu = (opc >= OP_ADD) && (opc <= OP_SRL);

  // Control: every register write in the core takes its data from the bus.
  always_comb begin
    state_nxt = state;
    bus_sel   = BUS_NONE;
    done      = 1'b0;
    rx_we     = 1'b0;
    a_we      = 1'b0;
    g_we      = 1'b0;
    mem_start = 1'b0;
    case (state)
      T0: begin
        if (bus.Run) state_nxt = T1;
      end
      T1: begin
        case (opc)
          OP_LD: begin
            bus_sel   = BUS_RY;
            mem_start = 1'b1;
            state_nxt = MW;
          end
          OP_ST: begin
            bus_sel   = BUS_RX;
            mem_start = 1'b1;
            state_nxt = MW;
          end
          OP_MVNZ: begin
            bus_sel   = BUS_RY;
            rx_we     = (g != '0);
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_MV: begin
            bus_sel   = BUS_RY;
            rx_we     = 1'b1;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            bus_sel   = BUS_DIN;
            rx_we     = 1'b1;
            done      = 1'b1;
            state_nxt = T0;
          end
          default: begin
            if (is_alu) begin
              bus_sel   = BUS_RX;
              a_we      = 1'b1;
              state_nxt = T2;
            end else begin
              done      = 1'b1;
              state_nxt = T0;
            end
          end
        endcase
      end
      T2: begin
        g_we      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        bus_sel   = BUS_G;
        rx_we     = 1'b1;
        done      = 1'b1;
        state_nxt = T0;
      end
      MW: begin
        if (bus.MemAck) begin
          done      = 1'b1;
          state_nxt = T0;
          if (opc == OP_LD) begin
            bus_sel = BUS_DIN;
            rx_we   = 1'b1;
          end
        end
      end
      default: state_nxt = T0;
    endcase
  end

  always_comb begin
    bus_val = '0;
    case (bus_sel)
      BUS_RX:  bus_val = rx_val;
      BUS_RY:  bus_val = ry_val;
      BUS_DIN: bus_val = bus.DIN;
      BUS_G:   bus_val = g;
      default: bus_val = '0;
    endcase
  end

  // State and datapath registers; reset aborts any instruction and drops MemReq at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= T0;
      ir      <= '0;
      a       <= '0;
      g       <= '0;
      addr    <= '0;
      dout    <= '0;
      w       <= 1'b0;
      mem_req <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && bus.Run) ir <= bus.DIN[IR_W-1:0];
      if (rx_we) regs[x_idx] <= bus_val;
      if (a_we) a <= bus_val;
      if (g_we) g <= alu(opc, a, ry_val);
      if (mem_start) begin
        addr    <= ry_val;
        mem_req <= 1'b1;
        w       <= (opc == OP_ST);
        if (opc == OP_ST) dout <= bus_val;
      end
      if (state == MW && bus.MemAck) begin
        mem_req <= 1'b0;
        w       <= 1'b0;
      end
    end
  end

  assign bus.Done     = done;
  assign bus.BusWires = bus_val;
  assign bus.ADDR     = addr;
  assign bus.DOUT     = dout;
  assign bus.W        = w;
  assign bus.MemReq   = mem_req;
endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: a 16-bit/8-register core for the main instruction set
// and memory port, plus a 32-bit/16-register core for wide shifts and wrap-around.
module tb_proc_param;
  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_MVNZ = 4'd2;
  localparam logic [3:0] OP_MV   = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_RSV  = 4'd12;

  logic clk = 1'b0;
  logic rstn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  proc_param_if #(.DATA_W(16)) if16 ();
  proc_param_if #(.DATA_W(32)) if32 ();

  proc_param #(.DATA_W(16), .NREG(8))  dut16 (.Clock(clk), .Resetn(rstn), .bus(if16.master));
  proc_param #(.DATA_W(32), .NREG(16)) dut32 (.Clock(clk), .Resetn(rstn), .bus(if32.master));

  function automatic logic [15:0] enc16(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    return {6'd0, op, x, y};
  endfunction

  function automatic logic [31:0] enc32(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    return {20'd0, op, x, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction on the 16-bit core; MemAck is raised after 'waits' idle MW cycles.
  task automatic exec16(input logic [15:0] instr, input logic [15:0] imm, input int waits,
                        input logic [15:0] mdata, output int ncyc, output logic [15:0] dbus,
                        output int mreq_n, output logic [15:0] maddr, output logic [15:0] mdout,
                        output logic mw);
    ncyc = 0; mreq_n = 0; dbus = '0; maddr = '0; mdout = '0; mw = 1'b0;
    @(negedge clk); cyc++;
    if16.Run = 1'b1; if16.DIN = instr; if16.MemAck = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); cyc++;
      if16.Run    = 1'b0;
      if16.DIN    = (k >= 2) ? mdata : imm;
      if16.MemAck = (k == 2 + waits);
      #1;
      if (if16.MemReq) mreq_n++;
      if (if16.Done) begin
        ncyc  = k + 1;
        dbus  = if16.BusWires;
        maddr = if16.ADDR;
        mdout = if16.DOUT;
        mw    = if16.W;
        break;
      end
    end
  endtask

  task automatic exec32(input logic [31:0] instr, input logic [31:0] imm,
                        output int ncyc, output logic [31:0] dbus);
    ncyc = 0; dbus = '0;
    @(negedge clk);
    if32.Run = 1'b1; if32.DIN = instr; if32.MemAck = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if32.Run = 1'b0;
      if32.DIN = imm;
      #1;
      if (if32.Done) begin
        ncyc = k + 1;
        dbus = if32.BusWires;
        break;
      end
    end
  endtask

  task automatic peek16(input logic [2:0] r, output logic [15:0] v);
    int n, m; logic [15:0] a, d; logic ww;
    exec16(enc16(OP_MV, r, r), 16'h0, 0, 16'h0, n, v, m, a, d, ww);
  endtask

  initial begin
    int          n, mq;
    logic [15:0] b, ad, dd, v;
    logic        wv;
    logic [31:0] b32;

    rstn = 1'b1;
    if16.Run = 1'b0; if16.DIN = '0; if16.MemAck = 1'b0;
    if32.Run = 1'b0; if32.DIN = '0; if32.MemAck = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done",   if16.Done, 0);
    chk("rst_memreq", if16.MemReq, 0);
    chk("rst_w",      if16.W, 0);
    chk("rst_addr",   if16.ADDR, 0);
    chk("rst_dout",   if16.DOUT, 0);
    chk("rst_bus",    if16.BusWires, 0);
    chk("rst_done32", if32.Done, 0);
    @(negedge clk); rstn = 1'b1;
    cyc = 0;

    exec16(enc16(OP_MVI, 1, 0), 16'h0005, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("mvi1_lat", n, 2); chk("mvi1_cyc", cyc, 2); chk("mvi1_bus", b, 16'h0005);
    exec16(enc16(OP_MVI, 2, 0), 16'h0003, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("mvi2_cyc", cyc, 4);
    exec16(enc16(OP_ADD, 1, 2), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("add_lat", n, 4); chk("add_cyc", cyc, 8); chk("add_bus", b, 16'h0008);
    peek16(1, v); chk("add_r1", v, 16'h0008);

    exec16(enc16(OP_SUB, 2, 1), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("sub_lat", n, 4); chk("sub_g", b, 16'hFFFB);
    peek16(2, v); chk("sub_r2", v, 16'hFFFB);
    exec16(enc16(OP_SLT, 2, 1), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("slt_g", b, 16'h0001);
    peek16(2, v); chk("slt_r2", v, 16'h0001);

    exec16(enc16(OP_SUB, 6, 6), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("sub0_g", b, 16'h0000);
    exec16(enc16(OP_MVNZ, 3, 1), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("mvnz0_lat", n, 2);
    peek16(3, v); chk("mvnz0_r3", v, 16'h0000);
    exec16(enc16(OP_SLT, 6, 1), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("slt_pos_g", b, 16'h0001);
    exec16(enc16(OP_MVNZ, 3, 1), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    peek16(3, v); chk("mvnz1_r3", v, 16'h0008);

    exec16(enc16(OP_MVI, 4, 0), 16'h0020, 0, 16'h0, n, b, mq, ad, dd, wv);
    exec16(enc16(OP_OR, 6, 4), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("or_g", b, 16'h0021);
    exec16(enc16(OP_RSV, 1, 2), 16'h0, 0, 16'h0, n, b, mq, ad, dd, wv);
    chk("rsv_lat", n, 2); chk("rsv_bus", b, 16'h0000);
    peek16(1, v); chk("rsv_r1", v, 16'h0008);

    exec16(enc16(OP_ST, 1, 4), 16'h0, 2, 16'h0, n, b, mq, ad, dd, wv);
    chk("st_lat", n, 5); chk("st_req_cycles", mq, 3); chk("st_addr", ad, 16'h0020);
    chk("st_dout", dd, 16'h0008); chk("st_w", wv, 1); chk("st_bus", b, 16'h0000);
    @(negedge clk); if16.MemAck = 1'b0; #1;
    chk("st_req_drop", if16.MemReq, 0); chk("st_w_drop", if16.W, 0);

    exec16(enc16(OP_LD, 5, 4), 16'h0, 1, 16'hBEEF, n, b, mq, ad, dd, wv);
    chk("ld_lat", n, 4); chk("ld_bus", b, 16'hBEEF); chk("ld_req_cycles", mq, 2);
    chk("ld_addr", ad, 16'h0020); chk("ld_w", wv, 0);
    peek16(5, v); chk("ld_r5", v, 16'hBEEF);

    @(negedge clk); if16.Run = 1'b1; if16.DIN = enc16(OP_LD, 5, 4); if16.MemAck = 1'b0;
    @(negedge clk); if16.Run = 1'b0;
    @(negedge clk); #1;
    chk("mw_req", if16.MemReq, 1);
    rstn = 1'b0; #1;
    chk("mw_rst_req", if16.MemReq, 0); chk("mw_rst_done", if16.Done, 0);
    chk("mw_rst_addr", if16.ADDR, 0); chk("mw_rst_dout", if16.DOUT, 0);
    @(negedge clk); rstn = 1'b1;
    peek16(1, v); chk("post_rst_r1", v, 16'h0000);
    peek16(5, v); chk("post_rst_r5", v, 16'h0000);

    exec32(enc32(OP_MVI, 0, 0), 32'd35, n, b32);
    exec32(enc32(OP_MVI, 15, 0), 32'd1, n, b32);
    exec32(enc32(OP_SLL, 15, 0), 32'd0, n, b32);
    chk("sll32_lat", n, 4); chk("sll32_g", b32, 32'h0000_0008);
    exec32(enc32(OP_MVI, 14, 0), 32'h8000_0000, n, b32);
    exec32(enc32(OP_MVI, 13, 0), 32'd31, n, b32);
    exec32(enc32(OP_SRL, 14, 13), 32'd0, n, b32);
    chk("srl32_g", b32, 32'h0000_0001);
    exec32(enc32(OP_MVI, 12, 0), 32'hFFFF_FFFF, n, b32);
    exec32(enc32(OP_MVI, 11, 0), 32'd2, n, b32);
    exec32(enc32(OP_ADD, 12, 11), 32'd0, n, b32);
    chk("add32_wrap", b32, 32'h0000_0001);
    exec32(enc32(OP_MV, 3, 12), 32'd0, n, b32);
    chk("mv32_r12", b32, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
Parametrised multicycle processor core, the successor to the fixed 16-bit/8-register core. Register count and datapath width are configurable, and the ALU set is complete. Adds load/store through an external memory port with a req/ack handshake, and a general-purpose register file with a shared bus. Instructions and immediates are fetched from DIN under Run; completion is signalled on Done.

Parameters:
DATA_W, 16, datapath/register/bus width; must be >= IR_W and >= 4.
NREG, 8, number of general registers; power of two, 2..16.
RW, $clog2(NREG), register-field width (derived, not overridden).
IR_W, 4+2*RW, instruction width: IR[IR_W-1 -: 4] opcode, then X field, then Y field (derived).

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  asynchronous active-low reset.
Run  in  1  start request, sampled only in state T0.
DIN  in  DATA_W  instruction word (low IR_W bits), mvi immediate, ld read data.
Done  out  1  high in the completion cycle of each instruction.
BusWires  out  DATA_W  current internal bus value; 0 when nothing drives.
ADDR  out  DATA_W  memory address, registered.
DOUT  out  DATA_W  memory write data, registered.
W  out  1  write strobe accompanying MemReq (1 = store).
MemReq  out  1  memory request, held until MemAck.
MemAck  in  1  memory completion; ld data is valid on DIN in the same cycle.

Behaviour:
- Reset (async, Resetn=0): R0..R(NREG-1), A, G, IR, ADDR, DOUT cleared to 0; W=0, MemReq=0; state=T0. Done is 0 during reset. Reset mid-instruction aborts it and drops MemReq immediately.
- States: T0 (fetch), T1, T2, T3, MW (memory wait).
- T0: if Run=1, IR<=DIN[IR_W-1:0] and go to T1; otherwise stay in T0. No register writes in T0.
- Opcodes (X=IR x-field, Y=IR y-field):
  - 0 ld: T1 ADDR<=RY, W<=0, MemReq<=1, go MW. MW: wait; when MemAck=1, RX<=DIN, Done=1, MemReq<=0, go T0.
  - 1 st: T1 ADDR<=RY, DOUT<=RX, W<=1, MemReq<=1, go MW. MW: when MemAck=1, Done=1, MemReq<=0, W<=0, go T0.
  - 2 mvnz: T1 if G!=0 then RX<=RY; Done=1 either way; go T0.
  - 3 mv: T1 RX<=RY, Done=1, go T0.
  - 4 mvi: T1 RX<=DIN (immediate word presented in T1), Done=1, go T0.
  - 5..10 add/sub/or/slt/sll/srl: T1 A<=RX. T2 G<=A op RY. T3 RX<=G, Done=1, go T0.
  - 11..15 reserved: T1 Done=1, no state change, go T0.
- ALU rules:
  - add/sub wrap modulo 2^DATA_W.
  - or is bitwise.
  - slt gives G=1 if signed A < signed RY, else 0.
  - sll/srl are logical shifts of A by RY[$clog2(DATA_W)-1:0].
- G holds its value between instructions; only ALU ops write G.
- MW has no timeout. MemAck outside MW is ignored. MemAck in the same cycle MemReq first rises is not possible, because MemReq is registered, so the earliest completion is the cycle after T1.
- Latency from the T0 fetch edge:
  - mv/mvnz/mvi/reserved: Done in T1, 2 cycles total.
  - ALU ops: Done in T3, 4 cycles.
  - ld/st: 3 cycles plus memory wait cycles.
- Done is combinational from state (Mealy on MemAck in MW) and is a single-cycle pulse per instruction.
- Bus driver, one per cycle:
  - RY in T1 for mv/mvnz/ld.
  - RX in T1 for st/ALU.
  - DIN in T1 for mvi and in MW when MemAck for ld.
  - G in T3.
  - 0 otherwise.
- Run is ignored outside T0. Back-to-back instructions are allowed: T0 follows the completion cycle directly.

Test Plan:
- Reset then mvi R1,#0x0005; mvi R2,#0x0003; add R1,R2 -> R1=0x0008, Done pulses at cycles 2, 4, 8 after the first Run, BusWires=0x0008 in T3.
- sub R2,R1 with R2=3, R1=8 -> R2=0xFFFB, G=0xFFFB; then slt R2,R1 -> R2=1 (signed -5<8).
- mvnz R3,R1 after G=0 -> R3 unchanged, Done=1 in T1; after G=1 -> R3=R1.
- st R1,[R4] with R4=0x0020, MemAck delayed 3 cycles -> ADDR=0x0020, DOUT=R1, W=1, MemReq held 3 cycles, Done on the ack cycle, then MemReq=W=0.
- ld R5,[R4] with MemAck+DIN=0xBEEF after 1 wait -> R5=0xBEEF; reset asserted mid-MW on a repeat -> MemReq drops at once, all registers 0, state T0.
- DATA_W=32, NREG=16 build: sll R15,R0 with R0=35 -> shift by 3; srl 0x80000000 by 31 -> 0x00000001.
